// File: rtl/diff_vector_harness_if.sv
// Signal bundle between the host/loader, the DUT pair and the differential harness.
// The harness uses the slave view; a loader or bench drives the master view.
interface diff_vector_harness_if #(
   parameter int IN_W  = 52,
   parameter int OUT_W = 924,
   parameter int AW    = 5,
   parameter int SIG_W = 32
);
   logic             vec_we;
   logic [AW-1:0]    vec_addr;
   logic [IN_W-1:0]  vec_wdata;
   logic [AW:0]      num_vec;
   logic             start;
   logic [IN_W-1:0]  dut_in;
   logic [OUT_W-1:0] dut_a_y;
   logic [OUT_W-1:0] dut_b_y;
   logic             busy;
   logic             done;
   logic             mismatch;
   logic [AW-1:0]    first_bad_idx;
   logic [AW:0]      bad_count;
   logic [SIG_W-1:0] sig_a;
   logic [SIG_W-1:0] sig_b;

   modport master (
      output vec_we, vec_addr, vec_wdata, num_vec, start, dut_a_y, dut_b_y,
      input  dut_in, busy, done, mismatch, first_bad_idx, bad_count, sig_a, sig_b
   );

   modport slave (
      input  vec_we, vec_addr, vec_wdata, num_vec, start, dut_a_y, dut_b_y,
      output dut_in, busy, done, mismatch, first_bad_idx, bad_count, sig_a, sig_b
   );
endinterface

// File: rtl/diff_vector_harness.sv
// Differential replay harness: drives a stored vector table into two DUT builds,
// flags A/B output differences and compacts each output stream into a MISR signature.
//
// state | meaning
// IDLE  | waiting for start, dut_in = 0; also a one-cycle hop for an empty run
// RUN   | replaying vectors, sampling both DUTs once per vector
// DONE  | results valid and stable until the next start or reset
module diff_vector_harness #(
   parameter int               IN_W   = 52,
   parameter int               OUT_W  = 924,
   parameter int               DEPTH  = 32,
   parameter int               AW     = 5,
   parameter int               SIG_W  = 32,
   parameter logic [SIG_W-1:0] POLY   = 32'h04C11DB7,
   parameter int               SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   diff_vector_harness_if.slave bus
);
   localparam int NCH = (OUT_W + SIG_W - 1) / SIG_W;
   localparam int HW  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [IN_W-1:0]      mem [DEPTH];
   logic [AW:0]          n_run;
   logic [AW:0]          n_sel;
   logic [AW-1:0]        idx;
   logic [HW-1:0]        hold;
   logic                 prime;
   logic                 empty_run;
   logic                 addr_ok;
   logic                 wr_ok;
   logic                 start_ok;
   logic                 sample;
   logic                 last;
   logic [IN_W-1:0]      first_vec;
   logic [NCH*SIG_W-1:0] pad_a;
   logic [NCH*SIG_W-1:0] pad_b;
   logic [SIG_W-1:0]     fold_a;
   logic [SIG_W-1:0]     fold_b;

   logic [IN_W-1:0]      dut_in_q;
   logic                 mismatch_q;
   logic [AW-1:0]        first_bad_q;
   logic [AW:0]          bad_count_q;
   logic [SIG_W-1:0]     sig_a_q;
   logic [SIG_W-1:0]     sig_b_q;

   function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] sig,
                                                  input logic [SIG_W-1:0] fold);
      return (sig << 1) ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
   endfunction

   if (DEPTH < (1 << AW)) begin : g_addr_chk
      assign addr_ok = (bus.vec_addr < AW'(DEPTH));
   end else begin : g_addr_all
      assign addr_ok = 1'b1;
   end

   assign start_ok  = bus.start && (state != RUN);
   assign wr_ok     = bus.vec_we && (state != RUN) && addr_ok;
   assign n_sel     = (bus.num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.num_vec;
   assign sample    = (state == RUN) && !prime && (hold == HW'(SETTLE));
   assign last      = (({1'b0, idx} + (AW+1)'(1)) == n_run);
   // A write to entry 0 on the start edge must be seen by the run it launches.
   assign first_vec = (wr_ok && (bus.vec_addr == '0)) ? bus.vec_wdata : mem[0];

   always_comb begin
      pad_a = '0;
      pad_b = '0;
      pad_a[OUT_W-1:0] = bus.dut_a_y;
      pad_b[OUT_W-1:0] = bus.dut_b_y;
      fold_a = '0;
      fold_b = '0;
      for (int i = 0; i < NCH; i++) begin
         fold_a = fold_a ^ pad_a[i*SIG_W +: SIG_W];
         fold_b = fold_b ^ pad_b[i*SIG_W +: SIG_W];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[bus.vec_addr] <= bus.vec_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (start_ok) begin
               state_nxt = (n_sel == '0) ? IDLE : RUN;
            end else if (empty_run) begin
               state_nxt = DONE;
            end
         end
         RUN: begin
            if (sample && last) begin
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state == RUN);
      bus.done = (state == DONE);
   end

   // The first vector is held one extra (prime) cycle so the run length is
   // 1 + n*(SETTLE+1) cycles from the accepting edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dut_in_q    <= '0;
         mismatch_q  <= 1'b0;
         first_bad_q <= '0;
         bad_count_q <= '0;
         sig_a_q     <= '0;
         sig_b_q     <= '0;
         idx         <= '0;
         hold        <= '0;
         prime       <= 1'b0;
         empty_run   <= 1'b0;
         n_run       <= '0;
      end else begin
         empty_run <= 1'b0;
         if (start_ok) begin
            mismatch_q  <= 1'b0;
            first_bad_q <= '0;
            bad_count_q <= '0;
            sig_a_q     <= '0;
            sig_b_q     <= '0;
            n_run       <= n_sel;
            idx         <= '0;
            hold        <= '0;
            prime       <= (n_sel != '0);
            empty_run   <= (n_sel == '0);
            dut_in_q    <= (n_sel == '0) ? '0 : first_vec;
         end else if (state == RUN) begin
            if (prime) begin
               prime <= 1'b0;
            end else if (!sample) begin
               hold <= hold + HW'(1);
            end else begin
               if (bus.dut_a_y != bus.dut_b_y) begin
                  bad_count_q <= bad_count_q + (AW+1)'(1);
                  mismatch_q  <= 1'b1;
                  if (!mismatch_q) begin
                     first_bad_q <= idx;
                  end
               end
               sig_a_q <= misr_next(sig_a_q, fold_a);
               sig_b_q <= misr_next(sig_b_q, fold_b);
               hold    <= '0;
               if (last) begin
                  dut_in_q <= '0;
               end else begin
                  idx      <= idx + AW'(1);
                  dut_in_q <= mem[idx + AW'(1)];
               end
            end
         end
      end
   end

   assign bus.dut_in        = dut_in_q;
   assign bus.mismatch      = mismatch_q;
   assign bus.first_bad_idx = first_bad_q;
   assign bus.bad_count     = bad_count_q;
   assign bus.sig_a         = sig_a_q;
   assign bus.sig_b         = sig_b_q;
endmodule

// File: tb/tb_diff_vector_harness.sv
// Scoreboard bench for diff_vector_harness: two emulated DUT builds, a table-level
// reference model, and a monitor that checks each run's results when done rises.
module tb_diff_vector_harness;
   localparam int               IN_W   = 52;
   localparam int               OUT_W  = 924;
   localparam int               DEPTH  = 32;
   localparam int               AW     = 5;
   localparam int               SIG_W  = 32;
   localparam logic [SIG_W-1:0] POLY   = 32'h04C11DB7;
   localparam int               SETTLE = 1;
   localparam int               NCH    = (OUT_W + SIG_W - 1) / SIG_W;

   typedef struct {
      int               exp_cyc;
      int               busy_cyc;
      logic             mm;
      logic [AW-1:0]    fbi;
      logic [AW:0]      bc;
      logic [SIG_W-1:0] sa;
      logic [SIG_W-1:0] sb;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   diff_vector_harness_if #(.IN_W(IN_W), .OUT_W(OUT_W), .AW(AW), .SIG_W(SIG_W)) bus();

   diff_vector_harness #(
      .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .AW(AW),
      .SIG_W(SIG_W), .POLY(POLY), .SETTLE(SETTLE)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int               cyc = 0;
   int               checks = 0;
   int               errors = 0;
   logic [IN_W-1:0]  tbl [DEPTH];
   logic             fault_en = 1'b0;
   logic [IN_W-1:0]  fault_val = '0;
   logic [OUT_W-1:0] flip = '0;
   exp_t             sb_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [OUT_W-1:0] gen_y(input logic [IN_W-1:0] v);
      logic [OUT_W-1:0] y;
      logic [31:0] w;
      y = '0;
      for (int i = 0; i < NCH; i++) begin
         w = (v[31:0] * 32'(2*i+1)) ^ (32'(v[IN_W-1:32]) << (i % 8)) ^ 32'(i);
         for (int j = 0; j < 32; j++) begin
            if (i*32 + j < OUT_W) y[i*32 + j] = w[j];
         end
      end
      return y;
   endfunction

   function automatic logic [OUT_W-1:0] gen_b(input logic [IN_W-1:0] v);
      return gen_y(v) ^ ((fault_en && (v == fault_val)) ? flip : '0);
   endfunction

   assign bus.dut_a_y = gen_y(bus.dut_in);
   assign bus.dut_b_y = gen_b(bus.dut_in);

   // Bit b of y lands on signature bit b mod SIG_W.
   function automatic logic [SIG_W-1:0] fold(input logic [OUT_W-1:0] y);
      logic [SIG_W-1:0] f;
      f = '0;
      for (int b = 0; b < OUT_W; b++) f[b % SIG_W] = f[b % SIG_W] ^ y[b];
      return f;
   endfunction

   function automatic logic [SIG_W-1:0] misr(input logic [SIG_W-1:0] s, input logic [SIG_W-1:0] f);
      return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0) ^ f;
   endfunction

   function automatic exp_t model(input int nv, input int acc_edge);
      exp_t e;
      int n;
      logic [OUT_W-1:0] ya, yb;
      n = (nv > DEPTH) ? DEPTH : nv;
      e.exp_cyc  = acc_edge + 1 + n * (SETTLE + 1);
      e.busy_cyc = (n == 0) ? 0 : 1 + n * (SETTLE + 1);
      e.mm = 1'b0; e.fbi = '0; e.bc = '0; e.sa = '0; e.sb = '0;
      for (int k = 0; k < n; k++) begin
         ya = gen_y(tbl[k]);
         yb = gen_b(tbl[k]);
         if (ya != yb) begin
            if (!e.mm) e.fbi = AW'(k);
            e.mm = 1'b1;
            e.bc = e.bc + (AW+1)'(1);
         end
         e.sa = misr(e.sa, fold(ya));
         e.sb = misr(e.sb, fold(yb));
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_dut_in"}, 64'(bus.dut_in), 0);
      chk({tag, "_busy"}, 64'(bus.busy), 0);
      chk({tag, "_done"}, 64'(bus.done), 0);
      chk({tag, "_mismatch"}, 64'(bus.mismatch), 0);
      chk({tag, "_first_bad_idx"}, 64'(bus.first_bad_idx), 0);
      chk({tag, "_bad_count"}, 64'(bus.bad_count), 0);
      chk({tag, "_sig_a"}, 64'(bus.sig_a), 0);
      chk({tag, "_sig_b"}, 64'(bus.sig_b), 0);
   endtask

   // Monitor: each rising done retires one scoreboard entry.
   int   busy_cnt = 0;
   logic done_d = 1'b0;
   exp_t m_e;
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_cnt = 0;
         done_d = 1'b0;
      end else begin
         if (bus.busy) busy_cnt++;
         if (bus.done && !done_d) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: done rose at cycle %0d, expected no run", cyc);
            end else begin
               m_e = sb_q.pop_front();
               chk("latency", 64'(cyc), 64'(m_e.exp_cyc));
               chk("busy_cycles", 64'(busy_cnt), 64'(m_e.busy_cyc));
               chk("mismatch", 64'(bus.mismatch), 64'(m_e.mm));
               chk("first_bad_idx", 64'(bus.first_bad_idx), 64'(m_e.fbi));
               chk("bad_count", 64'(bus.bad_count), 64'(m_e.bc));
               chk("sig_a", 64'(bus.sig_a), 64'(m_e.sa));
               chk("sig_b", 64'(bus.sig_b), 64'(m_e.sb));
               chk("dut_in_after_run", 64'(bus.dut_in), 0);
            end
            busy_cnt = 0;
         end
         done_d = bus.done;
      end
   end

   task automatic write_vec(input logic [AW-1:0] a, input logic [IN_W-1:0] d);
      @(negedge clk);
      bus.vec_we = 1'b1; bus.vec_addr = a; bus.vec_wdata = d;
      tbl[a] = d;
      @(posedge clk); #1;
      bus.vec_we = 1'b0;
   endtask

   task automatic run(input int nv, input bit we0, input logic [IN_W-1:0] wd);
      @(negedge clk);
      bus.num_vec = (AW+1)'(nv);
      bus.start = 1'b1;
      if (we0) begin
         bus.vec_we = 1'b1; bus.vec_addr = '0; bus.vec_wdata = wd;
         tbl[0] = wd;
      end
      sb_q.push_back(model(nv, cyc + 1));
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.vec_we = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int c;
      c = 0;
      while (!bus.done && c < limit) begin
         @(negedge clk);
         c++;
      end
      if (!bus.done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: done=0 after %0d cycles, expected 1", limit);
      end
   endtask

   function automatic logic [IN_W-1:0] rand_vec();
      return IN_W'({$urandom(), $urandom()});
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      int c;
      bus.vec_we = 1'b0; bus.vec_addr = '0; bus.vec_wdata = '0;
      bus.num_vec = '0; bus.start = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;

      // Distinct, non-zero vectors in every entry.
      for (int k = 0; k < DEPTH; k++)
         write_vec(AW'(k), {1'b1, 19'($urandom()), 27'($urandom()), 5'(k)});

      // Matching builds, three vectors.
      fault_en = 1'b0;
      run(3, 1'b0, '0);
      wait_done(100);

      // Build B flips y bit 0 on vector 1 only.
      fault_en = 1'b1; fault_val = tbl[1]; flip = '0; flip[0] = 1'b1;
      run(3, 1'b0, '0);
      wait_done(100);

      // Empty run.
      run(0, 1'b0, '0);
      wait_done(20);

      // Reset while vector 2 is on the bus, then rerun from the retained table.
      fault_en = 1'b0;
      run(3, 1'b0, '0);
      c = 0;
      while (bus.dut_in !== tbl[2] && c < 100) begin
         @(negedge clk);
         c++;
      end
      chk("reach_vec2", 64'(bus.dut_in), 64'(tbl[2]));
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_reset_vals("midrun_reset");
      sb_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run(3, 1'b0, '0);
      wait_done(100);

      // Oversized count clamps to the table depth; start/write while busy ignored.
      run(40, 1'b0, '0);
      repeat (10) @(negedge clk);
      bus.start = 1'b1; bus.num_vec = (AW+1)'(2);
      bus.vec_we = 1'b1; bus.vec_addr = AW'(3); bus.vec_wdata = ~tbl[3];
      @(posedge clk); #1;
      bus.start = 1'b0; bus.vec_we = 1'b0;
      wait_done(300);
      run(8, 1'b0, '0);
      wait_done(100);

      // Start from DONE together with a write to entry 0.
      run(5, 1'b1, {1'b1, 51'($urandom())});
      wait_done(100);

      for (int r = 0; r < 10; r++) begin
         int nw;
         nw = $urandom_range(0, 4);
         for (int w = 0; w < nw; w++) write_vec(AW'($urandom_range(0, DEPTH-1)), rand_vec());
         fault_en = 1'($urandom_range(0, 1));
         fault_val = tbl[$urandom_range(0, DEPTH-1)];
         flip = '0;
         flip[$urandom_range(0, OUT_W-1)] = 1'b1;
         run($urandom_range(0, 40), ($urandom_range(0, 3) == 0), rand_vec());
         wait_done(200);
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", 64'(sb_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
